// File: rtl/pipeline_perf_monitor.sv
// pipeline_perf_monitor: run/stall/flush/retire event counters with a cycle budget and registered readback
module pipeline_perf_monitor #(
  parameter int CNT_W      = 32,
  parameter int MAX_CYCLES = 30
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic             retire_i,
  input  logic             clear_i,
  input  logic [1:0]       rd_sel_i,
  output logic [CNT_W-1:0] rd_data_o,
  output logic [1:0]       state_o,
  output logic             halt_o
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  localparam logic [CNT_W-1:0] SAT   = '1;
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_CYCLES);
  state_t state, state_nx;
  logic [CNT_W-1:0] cyc, stl, fls, ret;
  logic [CNT_W-1:0] cyc_nx, stl_nx, fls_nx, ret_nx;
  logic run_en, hit, halt_nx;
  function automatic logic [CNT_W-1:0] inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && v != SAT) ? v + 1'b1 : v;
  endfunction
  assign run_en  = state == RUN && start_i;
  assign state_o = state;
  // next counters, budget detection and FSM transition; clear overrides everything
  always_comb begin
    cyc_nx   = clear_i ? '0 : inc(cyc, run_en);
    stl_nx   = clear_i ? '0 : inc(stl, run_en && stall_i);
    fls_nx   = clear_i ? '0 : inc(fls, run_en && flush_i);
    ret_nx   = clear_i ? '0 : inc(ret, run_en && retire_i);
    hit      = (MAX_CYCLES != 0) && run_en && cyc_nx == MAX_C;
    halt_nx  = !clear_i && (halt_o || hit);
    state_nx = clear_i          ? IDLE :
               state == IDLE    ? (start_i ? RUN : IDLE) :
               state == RUN     ? (!start_i ? IDLE : hit ? DONE : RUN) :
                                  DONE;
  end
  // state and counter registers; readback samples the counters before this edge's update
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      cyc       <= '0;
      stl       <= '0;
      fls       <= '0;
      ret       <= '0;
      halt_o    <= 1'b0;
      rd_data_o <= '0;
    end else begin
      state     <= state_nx;
      cyc       <= cyc_nx;
      stl       <= stl_nx;
      fls       <= fls_nx;
      ret       <= ret_nx;
      halt_o    <= halt_nx;
      rd_data_o <= rd_sel_i == 2'd0 ? cyc :
                   rd_sel_i == 2'd1 ? stl :
                   rd_sel_i == 2'd2 ? fls : ret;
    end
  end
endmodule

// File: tb/tb_pipeline_perf_monitor.sv
// tb_pipeline_perf_monitor: scoreboard bench driving directed vectors into two monitor configurations
module tb_pipeline_perf_monitor;
  logic        clk = 1'b0, rst = 1'b1;
  logic        start = 0, stall = 0, flush = 0, retire = 0, clear = 0;
  logic [1:0]  rd_sel = 0;
  logic [31:0] rd_data;
  logic [1:0]  state;
  logic        halt;
  logic        start6 = 0, stall6 = 0;
  logic [1:0]  rd_sel6 = 0;
  logic [3:0]  rd_data6;
  logic [1:0]  state6;
  logic        halt6;
  typedef struct {
    string       name;
    logic        which;
    logic [31:0] d;
    logic [1:0]  st;
    logic        h;
  } exp_t;
  exp_t        q[$];
  exp_t        e;
  logic        req = 0, req_d = 0;
  logic [31:0] ad;
  logic [1:0]  ast;
  logic        ah;
  int          passed = 0, total = 0;

  pipeline_perf_monitor u_dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .stall_i(stall), .flush_i(flush),
    .retire_i(retire), .clear_i(clear), .rd_sel_i(rd_sel), .rd_data_o(rd_data),
    .state_o(state), .halt_o(halt)
  );

  pipeline_perf_monitor #(.CNT_W(4), .MAX_CYCLES(0)) u_sat (
    .clk_i(clk), .rst_i(rst), .start_i(start6), .stall_i(stall6), .flush_i(1'b0),
    .retire_i(1'b0), .clear_i(1'b0), .rd_sel_i(rd_sel6), .rd_data_o(rd_data6),
    .state_o(state6), .halt_o(halt6)
  );

  always #5 clk = ~clk;

  always @(posedge clk) req_d <= req;

  // monitor: one read request per cycle, compared on the falling edge after it was sampled
  always @(negedge clk) begin
    if (req_d) begin
      total++;
      if (q.size() == 0) begin
        $display("FAIL scoreboard_empty: output presented with no expected entry");
      end else begin
        e   = q.pop_front();
        ad  = e.which ? {28'b0, rd_data6} : rd_data;
        ast = e.which ? state6 : state;
        ah  = e.which ? halt6 : halt;
        if (ad === e.d && ast === e.st && ah === e.h) passed++;
        else $display("FAIL %s: got data=%0d state=%0d halt=%0d, expected data=%0d state=%0d halt=%0d",
                      e.name, ad, ast, ah, e.d, e.st, e.h);
      end
    end
  end

  task automatic drive(input logic s, input logic st, input logic fl, input logic re);
    @(negedge clk);
    req = 0; clear = 0; start = s; stall = st; flush = fl; retire = re;
  endtask

  task automatic rd(input int sel, input string nm, input int d, input int sta, input logic h);
    @(negedge clk);
    clear = 0; rd_sel = 2'(sel); req = 1;
    q.push_back('{nm, 1'b0, 32'(d), 2'(sta), h});
  endtask

  task automatic rd6(input int sel, input string nm, input int d, input int sta, input logic h);
    @(negedge clk);
    clear = 0; rd_sel6 = 2'(sel); req = 1;
    q.push_back('{nm, 1'b1, 32'(d), 2'(sta), h});
  endtask

  task automatic clr(input int d);
    @(negedge clk);
    req = 1; clear = 1; start = 0; stall = 0; flush = 0; retire = 0; rd_sel = 2'd0;
    q.push_back('{"clear_edge", 1'b0, 32'(d), 2'd0, 1'b0});
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 0;
    rd(0, "reset_state", 0, 0, 0);
    // asynchronous reset in the middle of a run
    repeat (5) drive(1, 0, 0, 0);
    @(posedge clk);
    #2 rst = 1;
    #1;
    total++;
    if (state === 2'd0 && halt === 1'b0 && rd_data === 32'd0) passed++;
    else $display("FAIL async_reset: got data=%0d state=%0d halt=%0d, expected data=0 state=0 halt=0",
                  rd_data, state, halt);
    start = 0;
    @(negedge clk);
    rst = 0;
    // budget run with no events
    drive(1, 0, 0, 0);
    rd(0, "t1_run", 0, 1, 0);
    repeat (27) drive(1, 0, 0, 0);
    rd(0, "t1_edge30", 28, 1, 0);
    drive(1, 0, 0, 0);
    rd(0, "t1_done", 30, 2, 1);
    clr(30);
    rd(0, "clr_cyc", 0, 0, 0);
    rd(3, "clr_ret", 0, 0, 0);
    // event counting over a full budget
    drive(1, 0, 0, 0);
    for (int i = 0; i < 30; i++) drive(1, i == 2 || i == 5 || i == 9, i == 4 || i == 11, i < 20);
    rd(1, "t2_stl", 3, 2, 1);
    rd(2, "t2_fls", 2, 2, 1);
    rd(3, "t2_ret", 20, 2, 1);
    rd(0, "t2_cyc", 30, 2, 1);
    clr(30);
    // simultaneous stall+flush, then a pause with events that must be ignored
    drive(1, 0, 0, 0);
    drive(1, 1, 1, 0);
    repeat (9) drive(1, 0, 0, 0);
    drive(0, 1, 1, 1);
    drive(0, 1, 1, 1);
    rd(0, "t4_gap_cyc", 10, 0, 0);
    rd(1, "t3_stl", 1, 0, 0);
    rd(2, "t3_fls", 1, 0, 0);
    drive(1, 0, 0, 0);
    repeat (19) drive(1, 0, 0, 0);
    rd(0, "t4_done_edge", 29, 2, 1);
    repeat (3) drive(1, 1, 1, 1);
    rd(0, "done_frozen_cyc", 30, 2, 1);
    rd(1, "done_frozen_stl", 1, 2, 1);
    rd(3, "done_frozen_ret", 0, 2, 1);
    // saturation with a 4-bit counter and no budget
    @(negedge clk);
    req = 0; start = 0; stall = 0; flush = 0; retire = 0;
    start6 = 1; stall6 = 1;
    repeat (20) drive(0, 0, 0, 0);
    rd6(1, "t6_stl_sat", 15, 1, 0);
    rd6(0, "t6_cyc_sat", 15, 1, 0);
    repeat (3) drive(0, 0, 0, 0);
    if (q.size() != 0) begin
      total++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
